// File: rtl/lfsr_pair_source.sv
// Burst stimulus source: one 16-bit Galois LFSR split into two 8-bit operands,
// presented over valid/ready for NUM_WORDS transfers, then parked in DONE.
module lfsr_pair_source #(
    parameter logic [15:0] SEED      = 16'hACE1,
    parameter int          NUM_WORDS = 8,
    parameter logic [15:0] TAPS      = 16'hB400
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       out_ready,
    output logic       out_valid,
    output logic [7:0] out_a,
    output logic [7:0] out_b,
    output logic [7:0] word_count,
    output logic       busy,
    output logic       done
);

    // An all-zero LFSR locks up, so a zero seed falls back to the default.
    localparam logic [15:0] SEED_EFF  = (SEED == 16'h0000) ? 16'hACE1 : SEED;
    localparam logic [7:0]  LAST_WORD = 8'(NUM_WORDS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state, state_nx;
    logic [15:0] lfsr, lfsr_nx, lfsr_step;
    logic [7:0]  cnt, cnt_nx, cnt_inc;
    logic        xfer;

    // Handshake: a pair moves on every rising edge where out_valid && out_ready;
    // while out_valid is high and out_ready low, out_a/out_b/word_count hold.
    assign xfer      = (state == RUN) && out_ready;
    assign lfsr_step = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? TAPS : 16'h0000);
    assign cnt_inc   = cnt + 8'd1;

    always_comb begin
        state_nx = state;
        lfsr_nx  = lfsr;
        cnt_nx   = cnt;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = RUN;
                    lfsr_nx  = SEED_EFF;
                    cnt_nx   = 8'd0;
                end
            end
            RUN: begin
                if (xfer) begin
                    lfsr_nx = lfsr_step;
                    cnt_nx  = cnt_inc;
                    if (cnt_inc == LAST_WORD) begin
                        state_nx = DONE;
                    end
                end
            end
            DONE: begin
                // Restart replays the identical sequence from the seed.
                if (start) begin
                    state_nx = RUN;
                    lfsr_nx  = SEED_EFF;
                    cnt_nx   = 8'd0;
                end
            end
            default: begin
                state_nx = IDLE;
                lfsr_nx  = SEED_EFF;
                cnt_nx   = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            lfsr  <= SEED_EFF;
            cnt   <= 8'd0;
        end else begin
            state <= state_nx;
            lfsr  <= lfsr_nx;
            cnt   <= cnt_nx;
        end
    end

    assign out_valid  = (state == RUN);
    assign busy       = (state == RUN);
    assign done       = (state == DONE);
    assign out_a      = lfsr[15:8];
    assign out_b      = lfsr[7:0];
    assign word_count = cnt;

endmodule

// File: doc/lfsr_pair_source.md
Name: lfsr_pair_source

Overview:
Stimulus source that sits directly upstream of the bit-reverse stage. It produces two 8-bit operand words per transfer, taken from one 16-bit Galois LFSR, and presents them over a valid/ready handshake. It emits a bounded burst of NUM_WORDS transfers, then stops and reports done. The output sequence is deterministic and reproducible, so downstream results can be compared run to run.

Parameters:
SEED, 16'hACE1, initial LFSR state; a value of 0 is replaced by 16'hACE1 (an all-zero LFSR locks up)
NUM_WORDS, 8, number of transfers per burst; legal range 1..255
TAPS, 16'hB400, Galois feedback mask (x^16+x^14+x^13+x^11+1)

Ports:
clk  in  1  system clock, all state changes on its rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  single-cycle request to begin a burst
out_ready  in  1  downstream is able to accept the current word pair
out_valid  out  1  out_a/out_b hold a valid pair
out_a  out  8  operand A, equal to lfsr[15:8]
out_b  out  8  operand B, equal to lfsr[7:0]
word_count  out  8  transfers completed in the current burst
busy  out  1  high while in RUN
done  out  1  high in DONE; held until the next start

Behaviour:
- Reset, asynchronous on rst_n low:
  - state=IDLE, lfsr=effective SEED
  - out_valid=0, word_count=0, busy=0, done=0
  - out_a/out_b reflect the seed (0xAC/0xE1) but carry no meaning while out_valid=0.
- Deassertion of rst_n is assumed to be synchronous to clk externally; the block does not resynchronise it.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 -> RUN on the next edge; lfsr loaded with SEED, word_count cleared.
  - out_valid=1 in the first RUN cycle, so latency from start to first valid is 1 cycle.
- RUN:
  - out_valid=1 and busy=1.
  - A transfer occurs on any edge where out_valid && out_ready.
  - On each transfer: lfsr advances one step (lsb=lfsr[0]; lfsr=lfsr>>1; if lsb, lfsr^=TAPS) and word_count increments.
  - out_valid=1 with out_ready=0: out_a, out_b and word_count hold stable. No word is ever dropped or repeated.
  - Transfer that makes word_count==NUM_WORDS: -> DONE; out_valid drops on that same edge.
- DONE:
  - done=1, out_valid=0, word_count holds NUM_WORDS.
  - start=1 -> RUN with a reseed (identical sequence replayed); done and word_count cleared.
- start is ignored while in RUN.
- start and a final transfer on the same edge: enter DONE; start is not latched.
- out_ready while out_valid=0 has no effect.
- rst_n asserted mid-burst: immediate return to reset values; any partial burst is abandoned.
- word_count is 8 bits, so no wrap is possible within the legal NUM_WORDS range.
- The LFSR never reaches zero from a nonzero seed.
- Target size: one 16-bit register, an 8-bit counter, a 2-bit state register and output decode, roughly 120-180 lines.

Test Plan:
- Reset then hold: rst_n=0 for 3 cycles, then 1 with start=0 -> out_valid=0, busy=0, done=0, word_count=0 for 10 cycles.
- Burst with out_ready=1, pulse start -> one cycle later out_valid=1; pairs (a,b) = (AC,E1), (E2,70), (71,38), (38,9C), ...; exactly 8 transfers; done=1 after the 8th; word_count=8.
- Backpressure: out_ready toggles 1,0,0,1,... -> pair held stable while ready=0; the sequence matches the free-running case exactly (no skip or duplicate).
- Restart from DONE: pulse start -> the first pair is again (AC,E1); done clears on the same edge that busy rises.
- Reset mid-burst: assert rst_n=0 after 3 transfers -> outputs return to reset values within the same cycle, asynchronously; a subsequent start replays from (AC,E1).
- Corner parameters: SEED=0 -> behaves as SEED=16'hACE1; NUM_WORDS=1 -> one transfer, then DONE; start during RUN -> ignored, count unaffected.
